// File: rtl/vga_image_scanner.sv
// 640x480@60 raster scanner: fetches image bytes over the GPU read port and
// shows the encrypted and decrypted images side by side as grayscale.
module vga_image_scanner #(
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter int unsigned X0       = 32,
  parameter int unsigned X1       = 352,
  parameter int unsigned Y0       = 112,
  parameter int unsigned RD_LAT   = 1,
  parameter logic [7:0]  BG_COLOR = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [31:0] gpu_address,
  input  logic [7:0]  encrypted_gpu,
  input  logic [7:0]  decrypted_gpu,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);

  localparam int unsigned PIPE = 2 + RD_LAT;
  localparam int unsigned SH   = $clog2(IMG_W);

  typedef enum logic [1:0] {RG_BLANK, RG_BG, RG_ENC, RG_DEC} region_e;

  typedef struct packed {
    logic    hs;
    logic    vs;
    logic    vis;
    logic    fs;
    logic    en;
    region_e rg;
  } ctl_t;

  localparam ctl_t CTL_RST = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, fs: 1'b0,
                               en: 1'b0, rg: RG_BLANK};

  logic [9:0]  h_q, h_d, v_q, v_d;
  logic        enable_q, enable_d;
  logic [31:0] dy, dx_enc, dx_dec;
  logic        in_y, in_enc, in_dec;
  logic [31:0] addr_q, addr_d;
  ctl_t        ctl_d;
  ctl_t        ctl_q [PIPE-1];
  logic [7:0]  gray_q, gray_d;
  logic        hs_q, vs_q, vis_q, fs_q;

  // Raster counters; enable is only taken at the last pixel of the frame
  always_comb begin
    h_d      = (h_q == 10'd799) ? 10'd0 : h_q + 10'd1;
    v_d      = v_q;
    enable_d = enable_q;
    if (h_q == 10'd799) begin
      v_d = (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
      if (v_q == 10'd524) enable_d = enable;
    end
  end

  // Stage A: region decode and address. Out-of-range offsets wrap to huge
  // unsigned values, so a single compare covers both bounds.
  always_comb begin
    dy     = 32'(v_q) - Y0;
    dx_enc = 32'(h_q) - X0;
    dx_dec = 32'(h_q) - X1;
    in_y   = dy < IMG_H;
    in_enc = in_y && (dx_enc < IMG_W);
    in_dec = in_y && (dx_dec < IMG_W);

    ctl_d     = CTL_RST;
    ctl_d.vis = (h_q < 10'd640) && (v_q < 10'd480);
    ctl_d.hs  = !((h_q >= 10'd656) && (h_q < 10'd752));
    ctl_d.vs  = !((v_q >= 10'd490) && (v_q < 10'd492));
    ctl_d.fs  = (h_q == 10'd0) && (v_q == 10'd0);
    ctl_d.en  = enable_q;
    addr_d    = '0;
    if (!ctl_d.vis) begin
      ctl_d.rg = RG_BLANK;
    end else if (in_enc) begin
      ctl_d.rg = RG_ENC;
      addr_d   = (dy << SH) + dx_enc;
    end else if (in_dec) begin
      ctl_d.rg = RG_DEC;
      addr_d   = (dy << SH) + dx_dec;
    end else begin
      ctl_d.rg = RG_BG;
    end
  end

  // Output stage: ctl_q[PIPE-2] lines up with the memory data returning
  always_comb begin
    gray_d = 8'h00;
    unique case (ctl_q[PIPE-2].rg)
      RG_ENC:  gray_d = encrypted_gpu;
      RG_DEC:  gray_d = decrypted_gpu;
      RG_BG:   gray_d = BG_COLOR;
      default: gray_d = 8'h00;
    endcase
    if (!ctl_q[PIPE-2].en) gray_d = 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q      <= '0;
      v_q      <= '0;
      enable_q <= 1'b0;
      addr_q   <= '0;
      for (int i = 0; i < PIPE - 1; i++) ctl_q[i] <= CTL_RST;
      gray_q   <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      vis_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      enable_q <= enable_d;
      addr_q   <= addr_d;
      ctl_q[0] <= ctl_d;
      for (int i = 1; i < PIPE - 1; i++) ctl_q[i] <= ctl_q[i-1];
      gray_q   <= gray_d;
      hs_q     <= ctl_q[PIPE-2].hs;
      vs_q     <= ctl_q[PIPE-2].vs;
      vis_q    <= ctl_q[PIPE-2].vis;
      fs_q     <= ctl_q[PIPE-2].fs;
    end
  end

  assign gpu_address = addr_q;
  assign vga_hsync   = hs_q;
  assign vga_vsync   = vs_q;
  assign vga_blank_n = vis_q;
  assign vga_r       = gray_q;
  assign vga_g       = gray_q;
  assign vga_b       = gray_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_image_scanner.sv
// Bench for vga_image_scanner: probe table through a latency scoreboard,
// sync/frame timing from recorded edges, and an asynchronous mid-line reset.
module tb_vga_image_scanner;

  localparam int FRM = 420000;
  localparam int NV  = 17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] gpu_address;
  logic [7:0]  encrypted_gpu, decrypted_gpu;
  logic        vga_hsync, vga_vsync, vga_blank_n, frame_start;
  logic [7:0]  vga_r, vga_g, vga_b;

  vga_image_scanner #(.Y0(4), .IMG_H(64)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .gpu_address(gpu_address),
    .encrypted_gpu(encrypted_gpu), .decrypted_gpu(decrypted_gpu),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
  );

  always #20 clk = ~clk;

  // Memory model, one cycle read latency
  always @(posedge clk) begin
    encrypted_gpu <= gpu_address[7:0];
    decrypted_gpu <= ~gpu_address[7:0];
  end

  // Edges since reset release; counter value k is seen at the output at cyc k+3
  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  typedef struct {
    int          f;
    int          h;
    int          v;
    logic [31:0] addr;
    logic [7:0]  gray;
    logic        blank_n;
  } vec_t;

  typedef struct {
    int         due;
    int         idx;
    logic [7:0] gray;
    logic       blank_n;
  } sb_t;

  vec_t vt [NV];
  sb_t  sb [$];
  int   hs_falls [$], hs_rises [$], vs_falls [$], vs_rises [$], fs_cyc [$];
  logic prev_hs = 1'b1, prev_vs = 1'b1;
  bit   probes_on = 1'b0;
  int   total = 0, bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (prev_hs && !vga_hsync) hs_falls.push_back(cyc);
    if (!prev_hs && vga_hsync) hs_rises.push_back(cyc);
    if (prev_vs && !vga_vsync) vs_falls.push_back(cyc);
    if (!prev_vs && vga_vsync) vs_rises.push_back(cyc);
    if (frame_start) fs_cyc.push_back(cyc);
    prev_hs <= vga_hsync;
    prev_vs <= vga_vsync;
    if (probes_on) begin
      for (int i = 0; i < NV; i++) begin
        if (cyc == vt[i].f * FRM + vt[i].v * 800 + vt[i].h + 1) begin
          chk($sformatf("addr[%0d]", i), gpu_address, vt[i].addr);
          sb.push_back('{cyc + 2, i, vt[i].gray, vt[i].blank_n});
        end
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        sb_t e;
        e = sb.pop_front();
        chk($sformatf("pix[%0d]", e.idx), {vga_r, vga_g, vga_b, vga_blank_n},
            {e.gray, e.gray, e.gray, e.blank_n});
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hsync"}, vga_hsync, 1);
    chk({tag, "_vsync"}, vga_vsync, 1);
    chk({tag, "_blank_n"}, vga_blank_n, 0);
    chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_addr"}, gpu_address, 0);
  endtask

  initial begin
    // frame 0: enable_q still 0, so image/background are black
    vt[0]  = '{0, 37, 6, 32'd517, 8'h00, 1'b1};
    vt[1]  = '{0, 10, 10, 32'd0, 8'h00, 1'b1};
    vt[2]  = '{0, 639, 479, 32'd0, 8'h00, 1'b1};
    vt[3]  = '{0, 640, 479, 32'd0, 8'h00, 1'b0};
    vt[4]  = '{0, 0, 480, 32'd0, 8'h00, 1'b0};
    // frame 1: enable_q = 1
    vt[5]  = '{1, 37, 6, 32'd517, 8'h05, 1'b1};
    vt[6]  = '{1, 357, 6, 32'd517, 8'hFA, 1'b1};
    vt[7]  = '{1, 10, 10, 32'd0, 8'h20, 1'b1};
    vt[8]  = '{1, 700, 10, 32'd0, 8'h00, 1'b0};
    vt[9]  = '{1, 31, 6, 32'd0, 8'h20, 1'b1};
    vt[10] = '{1, 32, 4, 32'd0, 8'h00, 1'b1};
    vt[11] = '{1, 352, 4, 32'd0, 8'hFF, 1'b1};
    // enable drops at line 30; the rest of frame 1 must be unaffected
    vt[12] = '{1, 500, 40, 32'd9364, 8'h6B, 1'b1};
    vt[13] = '{1, 287, 67, 32'd16383, 8'hFF, 1'b1};
    vt[14] = '{1, 288, 67, 32'd0, 8'h20, 1'b1};
    vt[15] = '{1, 300, 68, 32'd0, 8'h20, 1'b1};
    vt[16] = '{1, 10, 100, 32'd0, 8'h20, 1'b1};

    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("rst0");
    @(negedge clk);
    rst_n     = 1'b1;
    probes_on = 1'b1;

    wait_cyc(FRM + 30 * 800);
    enable = 1'b0;

    // stop at counter (300,110) of frame 1, mid-line
    wait_cyc(FRM + 110 * 800 + 300);
    probes_on = 1'b0;
    chk("pre_rst_blank_n", vga_blank_n, 1);
    chk("pre_rst_rgb", {vga_r, vga_g, vga_b}, 24'h202020);
    chk("sb_drained", sb.size(), 0);

    chk("hs_fall0", hs_falls.size() > 1 ? hs_falls[0] : -1, 659);
    chk("hs_rise0", hs_rises.size() > 0 ? hs_rises[0] : -1, 755);
    chk("hs_fall1", hs_falls.size() > 1 ? hs_falls[1] : -1, 1459);
    chk("hs_period_wrap", hs_falls.size() > 600 ? hs_falls[600] - hs_falls[599] : -1, 800);
    chk("vs_fall0", vs_falls.size() > 0 ? vs_falls[0] : -1, 490 * 800 + 3);
    chk("vs_low", vs_rises.size() > 0 && vs_falls.size() > 0 ? vs_rises[0] - vs_falls[0] : -1, 1600);
    chk("fs_count", fs_cyc.size(), 2);
    chk("fs0", fs_cyc.size() > 0 ? fs_cyc[0] : -1, 3);
    chk("fs_period", fs_cyc.size() > 1 ? fs_cyc[1] - fs_cyc[0] : -1, FRM);

    // asynchronous reset between clock edges
    #5 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    hs_falls.delete();
    hs_rises.delete();
    fs_cyc.delete();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(1500);
    chk("hs_fall_rel", hs_falls.size() > 0 ? hs_falls[0] : -1, 659);
    chk("fs_rel", fs_cyc.size() > 0 ? fs_cyc[0] : -1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
